fft_frame_ctrl: RTL and testbench
=================================

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001: Parameter DATA_W, default 16, SHALL set the sample width in bits (signed two's complement).
REQ-002: Parameter FRAME_LEN, default 16, SHALL set samples per FFT frame; it SHALL be a power of two, 4..256.
REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: reset  input  1  SHALL be the asynchronous, active-low reset (0 = in reset).
REQ-005: sample_in  input  DATA_W  SHALL carry the filtered sample from the FIR stage.
REQ-006: sample_valid  input  1  SHALL qualify sample_in for one cycle per sample.
REQ-007: fft_ready  input  1  SHALL be high when the FFT can accept a new frame.
REQ-008: fft_done  input  1  SHALL be a one-cycle pulse from the FFT marking completion of the current frame.
REQ-009: fft_start  output  1  SHALL be a one-cycle pulse announcing a new frame.
REQ-010: fft_data  output  DATA_W  SHALL carry the frame samples to the FFT.
REQ-011: fft_data_valid  output  1  SHALL qualify fft_data.
REQ-012: fft_last  output  1  SHALL mark the final sample of a frame, coincident with fft_data_valid.
REQ-013: frame_count  output  16  SHALL count completed frames.
REQ-014: overrun  output  1  SHALL be a sticky flag indicating at least one dropped input sample.
REQ-015: busy  output  1  SHALL be high whenever the read FSM is not IDLE.

Function
REQ-016: Storage SHALL be two banks (ping-pong) of FRAME_LEN x DATA_W words, each with a full flag.
REQ-017: Write side: an accepted sample SHALL be stored at wr_ptr in bank wr_bank; wr_ptr increments.
REQ-018: When wr_ptr wraps from FRAME_LEN-1 to 0, the same edge SHALL set that bank's full flag and toggle wr_bank.
REQ-019: A sample arriving while bank wr_bank is full SHALL be dropped: no write, no pointer change, overrun set to 1.
REQ-020: Read FSM states SHALL be IDLE, START, STREAM, WAIT_DONE.
REQ-021: IDLE -> START when bank rd_bank is full and fft_ready=1; otherwise remain in IDLE.
REQ-022: START SHALL last exactly one cycle with fft_start=1, then go to STREAM.
REQ-023: STREAM SHALL output words 0..FRAME_LEN-1 of rd_bank on consecutive cycles with fft_data_valid=1 and no gaps.
REQ-024: fft_last SHALL be 1 only on word FRAME_LEN-1; on that edge the bank's full flag SHALL clear, rd_bank SHALL toggle, and the FSM SHALL go to WAIT_DONE.
REQ-025: WAIT_DONE -> IDLE on fft_done=1; the same edge SHALL increment frame_count, wrapping 65535 -> 0.
REQ-026: fft_done outside WAIT_DONE SHALL be ignored.
REQ-027: Latency: if the last sample of a frame is written at edge E and fft_ready=1, fft_start SHALL be high in the cycle after E+1, and word 0 SHALL be valid in the cycle after E+2.
REQ-028: A full-flag set by the write side and a clear by the read side in the same edge on different banks SHALL both take effect.
REQ-029: fft_data and fft_data_valid SHALL be registered; fft_data SHALL be held at its last value while fft_data_valid=0.
REQ-030: fft_ready is sampled only in IDLE; deassertion during STREAM SHALL NOT stall or abort the frame.

Reset
REQ-031: While reset=0, the FSM SHALL be IDLE; wr_ptr, wr_bank, rd_bank, full flags, fft_start, fft_data, fft_data_valid, fft_last, frame_count, overrun and busy SHALL all be 0.
REQ-032: Reset asserted mid-STREAM SHALL abort the frame immediately, and buffered data SHALL be discarded; bank contents need not be cleared.

Verification
REQ-033: Reset: assert reset=0 with random inputs -> all outputs 0; release -> outputs remain 0 until a frame fills.
REQ-034: Single frame: fft_ready=1, 16 valid samples 1..16 -> one fft_start pulse, fft_data 1..16 on 16 consecutive cycles, fft_last on 16, busy high START..WAIT_DONE; fft_done pulse -> frame_count=1.
REQ-035: Ping-pong: fft_ready=1, 32 back-to-back samples, fft_done 3 cycles after each fft_last -> two frames in order, overrun=0, frame_count=2.
REQ-036: Overrun: fft_ready=0, 33 samples -> both banks full, 33rd dropped, overrun=1 and sticky; raise fft_ready -> frames contain samples 1..16 then 17..32.
REQ-037: Reset mid-stream: reset=0 at word 5 of STREAM -> fft_data_valid=0 immediately; after release, a new 16-sample frame streams correctly with frame_count restarting at 0.
REQ-038: Wrap: preload via 65536 completed frames (or force) -> frame_count goes 65535 -> 0; stray fft_done in IDLE leaves frame_count unchanged.

Source files
------------

// File: rtl/fft_frame_ctrl_if.sv
// Frame-streaming bus between the frame controller and the FFT core.
// The controller owns start/data/valid/last. The FFT owns ready/done.
interface fft_frame_ctrl_if #(
  parameter int DATA_W = 16
) ();
  logic              fft_start;
  logic [DATA_W-1:0] fft_data;
  logic              fft_data_valid;
  logic              fft_last;
  logic              fft_ready;
  logic              fft_done;

  modport master (
    output fft_start, fft_data, fft_data_valid, fft_last,
    input  fft_ready, fft_done
  );

  modport slave (
    input  fft_start, fft_data, fft_data_valid, fft_last,
    output fft_ready, fft_done
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Ping-pong frame buffer between the FIR output and the FFT input.
// The write side fills one bank while the read FSM streams the other bank to the FFT.
module fft_frame_ctrl #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  fft_frame_ctrl_if.master         fft,
  output logic [15:0]              frame_count,
  output logic                     overrun,
  output logic                     busy
);
  localparam int PTR_W = $clog2(FRAME_LEN);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, START, STREAM, WAIT_DONE} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              wr_en;
  logic              load_word;

  logic [DATA_W-1:0] bank_mem [2][FRAME_LEN];

  // NOTE: sample storage has no reset so it maps onto plain RAM; the full flags alone say what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) bank_mem[wr_bank_q][wr_ptr_q] <= sample_in;
  end

  // NOTE: every variable gets a default before any branch, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    full_d        = full_q;
    overrun_d     = overrun_q;
    frame_count_d = frame_count_q;
    data_d        = data_q;
    valid_d       = 1'b0;
    last_d        = 1'b0;
    wr_en         = 1'b0;
    load_word     = 1'b0;

    // Write side: a sample landing on a full bank is dropped and flagged.
    if (sample_valid) begin
      if (full_q[wr_bank_q]) begin
        overrun_d = 1'b1;
      end else begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (wr_ptr_q == LAST_IDX) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q] && fft.fft_ready) state_d = START;
      end
      START: begin
        load_word = 1'b1;
        state_d   = STREAM;
      end
      STREAM: begin
        if (last_q) begin
          // The writer never touches a full bank, so this clear and any set above hit different banks.
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          state_d           = WAIT_DONE;
        end else begin
          load_word = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (fft.fft_done) begin
          frame_count_d = frame_count_q + 16'd1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_word) begin
      data_d   = bank_mem[rd_bank_q][rd_ptr_q];
      valid_d  = 1'b1;
      last_d   = (rd_ptr_q == LAST_IDX);
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      full_q        <= '0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      last_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      full_q        <= full_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      last_q        <= last_d;
    end
  end

  assign fft.fft_start      = (state_q == START);
  assign fft.fft_data       = data_q;
  assign fft.fft_data_valid = valid_q;
  assign fft.fft_last       = last_q;
  assign frame_count        = frame_count_q;
  assign overrun            = overrun_q;
  assign busy               = (state_q != IDLE);
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: reset, single frame, ping-pong, overrun,
// reset mid-stream and frame counter wrap, with hand-computed expectations.
module tb_fft_frame_ctrl;
  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 16;

  logic                     clk;
  logic                     reset;
  logic signed [DATA_W-1:0] sample_in;
  logic                     sample_valid;
  logic [15:0]              frame_count;
  logic                     overrun;
  logic                     busy;

  int errors = 0;
  int checks = 0;

  fft_frame_ctrl_if #(.DATA_W(DATA_W)) fft_bus ();

  fft_frame_ctrl #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .fft          (fft_bus),
    .frame_count  (frame_count),
    .overrun      (overrun),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    sample_valid    = 1'b0;
    sample_in       = '0;
    fft_bus.fft_ready = 1'b0;
    fft_bus.fft_done  = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic send_samples(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      sample_in    = 16'(first + i);
      sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (fft_bus.fft_start !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(fft_bus.fft_start), 32'd1);
  endtask

  task automatic expect_frame(input string tag, input int first);
    for (int k = 0; k < FRAME_LEN; k++) begin
      tick();
      check({tag, "_valid"}, 32'(fft_bus.fft_data_valid), 32'd1);
      check({tag, "_data"}, 32'(fft_bus.fft_data), 32'(16'(first + k)));
      check({tag, "_last"}, 32'(fft_bus.fft_last), (k == FRAME_LEN - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic done_pulse(input int delay);
    repeat (delay) tick();
    fft_bus.fft_done = 1'b1;
    tick();
    fft_bus.fft_done = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_start"}, 32'(fft_bus.fft_start), 32'd0);
    check({tag, "_data"}, 32'(fft_bus.fft_data), 32'd0);
    check({tag, "_valid"}, 32'(fft_bus.fft_data_valid), 32'd0);
    check({tag, "_last"}, 32'(fft_bus.fft_last), 32'd0);
    check({tag, "_count"}, 32'(frame_count), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset held with random inputs: every output stays zero.
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample_in         = 16'($urandom);
      sample_valid      = 1'($urandom);
      fft_bus.fft_ready = 1'($urandom);
      fft_bus.fft_done  = 1'($urandom);
      tick();
      check_quiet("rst_hold");
    end
    sample_valid      = 1'b0;
    fft_bus.fft_ready = 1'b0;
    fft_bus.fft_done  = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      tick();
      check_quiet("rst_release");
    end

    // Single frame with exact start/data latency.
    do_reset();
    fft_bus.fft_ready = 1'b1;
    send_samples(1, 16);
    tick();
    check("single_start", 32'(fft_bus.fft_start), 32'd1);
    check("single_busy_start", 32'(busy), 32'd1);
    check("single_no_valid_in_start", 32'(fft_bus.fft_data_valid), 32'd0);
    expect_frame("single", 1);
    tick();
    check("single_wait_valid", 32'(fft_bus.fft_data_valid), 32'd0);
    check("single_hold_data", 32'(fft_bus.fft_data), 32'd16);
    check("single_busy_wait", 32'(busy), 32'd1);
    check("single_count_before_done", 32'(frame_count), 32'd0);
    done_pulse(1);
    check("single_count", 32'(frame_count), 32'd1);
    check("single_idle", 32'(busy), 32'd0);

    // Ping-pong: 32 back-to-back samples, done three cycles after each last.
    do_reset();
    fft_bus.fft_ready = 1'b1;
    fork
      send_samples(101, 32);
      begin
        wait_start("pp_start0");
        expect_frame("pp_f0", 101);
        done_pulse(3);
        wait_start("pp_start1");
        expect_frame("pp_f1", 117);
        done_pulse(3);
      end
    join
    check("pp_overrun", 32'(overrun), 32'd0);
    check("pp_count", 32'(frame_count), 32'd2);

    // Overrun: FFT not ready, 33rd sample dropped, flag sticky.
    do_reset();
    send_samples(1, 33);
    tick();
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_idle", 32'(busy), 32'd0);
    repeat (4) tick();
    check("ovr_sticky", 32'(overrun), 32'd1);
    fft_bus.fft_ready = 1'b1;
    wait_start("ovr_start0");
    expect_frame("ovr_f0", 1);
    done_pulse(2);
    wait_start("ovr_start1");
    expect_frame("ovr_f1", 17);
    done_pulse(2);
    check("ovr_count", 32'(frame_count), 32'd2);
    check("ovr_still_set", 32'(overrun), 32'd1);

    // Reset asserted at word 5 of a stream aborts it at once.
    do_reset();
    fft_bus.fft_ready = 1'b1;
    send_samples(201, 16);
    wait_start("mid_start");
    for (int k = 0; k < 6; k++) begin
      tick();
      check("mid_data", 32'(fft_bus.fft_data), 32'(201 + k));
    end
    reset = 1'b0;
    #1;
    check("mid_abort_valid", 32'(fft_bus.fft_data_valid), 32'd0);
    check("mid_abort_busy", 32'(busy), 32'd0);
    check("mid_abort_data", 32'(fft_bus.fft_data), 32'd0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("mid_no_restart", 32'(busy), 32'd0);
    check("mid_count_zero", 32'(frame_count), 32'd0);
    send_samples(301, 16);
    wait_start("mid_new_start");
    expect_frame("mid_new", 301);
    done_pulse(1);
    check("mid_new_count", 32'(frame_count), 32'd1);

    // Counter wrap, stray done in IDLE, ready dropped mid-stream.
    do_reset();
    force dut.frame_count_q = 16'hFFFF;
    tick();
    release dut.frame_count_q;
    tick();
    check("wrap_preload", 32'(frame_count), 32'hFFFF);
    fft_bus.fft_done = 1'b1;
    tick();
    fft_bus.fft_done = 1'b0;
    tick();
    check("wrap_stray_done", 32'(frame_count), 32'hFFFF);
    fft_bus.fft_ready = 1'b1;
    send_samples(401, 16);
    wait_start("wrap_start");
    fft_bus.fft_ready = 1'b0;
    expect_frame("wrap_f", 401);
    done_pulse(1);
    check("wrap_count", 32'(frame_count), 32'd0);
    check("wrap_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
